// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings, stage-word widths and bubble words for the pipeline registers
package y86_pkg;
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [2:0] SBUB = 3'd0;
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SADR = 3'd2;
   localparam logic [2:0] SINS = 3'd3;
   localparam logic [2:0] SHLT = 3'd4;
   localparam logic [3:0] RRSP  = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] FNONE = 4'h0;
   // D: stat icode ifun rA rB valC valP
   localparam int D_W = 3 + 4 + 4 + 4 + 4 + 64 + 64;
   localparam logic [D_W-1:0] D_BUBBLE = {SBUB, INOP, FNONE, RNONE, RNONE, 64'h0, 64'h0};
   // E: stat icode ifun valC valA valB dstE dstM srcA srcB
   localparam int E_W = 3 + 4 + 4 + 64 + 64 + 64 + 4 + 4 + 4 + 4;
   localparam logic [E_W-1:0] E_BUBBLE = {SBUB, INOP, FNONE, 192'h0, RNONE, RNONE, RNONE, RNONE};
   // M: stat icode Cnd valE valA dstE dstM
   localparam int M_W = 3 + 4 + 1 + 64 + 64 + 4 + 4;
   localparam logic [M_W-1:0] M_BUBBLE = {SBUB, INOP, 1'b0, 128'h0, RNONE, RNONE};
   // W: stat icode valE valM dstE dstM
   localparam int W_W = 3 + 4 + 64 + 64 + 4 + 4;
   localparam logic [W_W-1:0] W_BUBBLE = {SBUB, INOP, 128'h0, RNONE, RNONE};
   typedef enum logic {EMPTY, FULL} skid_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones; ports clock, reset (sync), inc, count
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge clock)
      count <= reset ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: stage register with valid bit, optional one-entry skid buffer and stall/bubble counters
// in:  clock, reset (sync, high), in_data/in_valid, stall, bubble
// out: out_data/out_valid, skid_full, overflow (sticky lost word), stall_cycles, bubble_count
module pipe_stage_reg
   import y86_pkg::*;
#(
   parameter int               WIDTH      = 64,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
   parameter int               SKID       = 0,
   parameter int               CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             bubble,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             skid_full,
   output logic             overflow,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count
);
   skid_state_t      state, state_n;
   logic [WIDTH-1:0] skid_q, skid_n, data_n;
   logic             valid_n, ovf_n;
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= EMPTY;
         skid_q    <= BUBBLE_VAL;
         out_data  <= BUBBLE_VAL;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_n;
         skid_q    <= skid_n;
         out_data  <= data_n;
         out_valid <= valid_n;
         overflow  <= ovf_n;
      end
   end
   // state can only leave EMPTY when SKID is enabled, so SKID=0 reduces to a plain stall/bubble register
   always_comb begin
      state_n = state;
      skid_n  = skid_q;
      data_n  = out_data;
      valid_n = out_valid;
      ovf_n   = overflow;
      if (stall) begin
         if (SKID != 0 && in_valid) begin
            if (state == FULL) ovf_n = 1'b1;
            else begin
               skid_n  = in_data;
               state_n = FULL;
            end
         end
      end else if (bubble) begin
         // squash: both the skid word and the incoming word are flushed
         data_n  = BUBBLE_VAL;
         valid_n = 1'b0;
         skid_n  = BUBBLE_VAL;
         state_n = EMPTY;
      end else if (state == FULL) begin
         data_n  = skid_q;
         valid_n = 1'b1;
         skid_n  = in_valid ? in_data : skid_q;
         state_n = in_valid ? FULL : EMPTY;
      end else begin
         data_n  = in_data;
         valid_n = in_valid;
      end
   end
   assign skid_full = (state == FULL);
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock(clock),
      .reset(reset),
      .inc  (stall),
      .count(stall_cycles)
   );
   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clock(clock),
      .reset(reset),
      .inc  (!stall && bubble),
      .count(bubble_count)
   );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of three pipe_stage_reg configurations against a queue model
module tb_pipe_stage_reg;
   logic       clock;
   logic [7:0] din [3];
   logic       iv [3], st [3], bb [3], rs [3];
   logic [7:0] dout [3];
   logic       ov [3], sf [3], of [3];
   logic [15:0] sc0, bc0, sc1, bc1;
   logic [3:0]  sc2, bc2;
   int passed = 0, total = 0;
   // reference model: held word as a bounded queue, counters as plain ints
   logic [7:0] m_out [3];
   logic       m_v [3];
   logic       m_ovf [3];
   logic [7:0] m_q [$];
   int         m_sc [3], m_bc [3];
   pipe_stage_reg #(.WIDTH(8), .BUBBLE_VAL(8'h10), .SKID(0), .CNT_W(16)) u0 (
      .clock(clock), .reset(rs[0]), .in_data(din[0]), .in_valid(iv[0]), .stall(st[0]), .bubble(bb[0]),
      .out_data(dout[0]), .out_valid(ov[0]), .skid_full(sf[0]), .overflow(of[0]),
      .stall_cycles(sc0), .bubble_count(bc0));
   pipe_stage_reg #(.WIDTH(8), .BUBBLE_VAL(8'h10), .SKID(1), .CNT_W(16)) u1 (
      .clock(clock), .reset(rs[1]), .in_data(din[1]), .in_valid(iv[1]), .stall(st[1]), .bubble(bb[1]),
      .out_data(dout[1]), .out_valid(ov[1]), .skid_full(sf[1]), .overflow(of[1]),
      .stall_cycles(sc1), .bubble_count(bc1));
   pipe_stage_reg #(.WIDTH(8), .BUBBLE_VAL(8'h10), .SKID(0), .CNT_W(4)) u2 (
      .clock(clock), .reset(rs[2]), .in_data(din[2]), .in_valid(iv[2]), .stall(st[2]), .bubble(bb[2]),
      .out_data(dout[2]), .out_valid(ov[2]), .skid_full(sf[2]), .overflow(of[2]),
      .stall_cycles(sc2), .bubble_count(bc2));
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   function automatic int sat_inc(int v, int mx);
      return (v < mx) ? v + 1 : mx;
   endfunction
   task automatic model_update();
      for (int i = 0; i < 3; i++) begin
         int mx;
         mx = (i == 2) ? 15 : 65535;
         if (rs[i]) begin
            m_out[i] = 8'h10; m_v[i] = 1'b0; m_ovf[i] = 1'b0; m_sc[i] = 0; m_bc[i] = 0;
            if (i == 1) m_q.delete();
         end else if (st[i]) begin
            m_sc[i] = sat_inc(m_sc[i], mx);
            if (i == 1 && iv[i]) begin
               if (m_q.size() == 0) m_q.push_back(din[i]);
               else m_ovf[i] = 1'b1;
            end
         end else if (bb[i]) begin
            m_bc[i] = sat_inc(m_bc[i], mx);
            m_out[i] = 8'h10; m_v[i] = 1'b0;
            if (i == 1) m_q.delete();
         end else if (i == 1 && m_q.size() != 0) begin
            m_out[i] = m_q.pop_front(); m_v[i] = 1'b1;
            if (iv[i]) m_q.push_back(din[i]);
         end else begin
            m_out[i] = din[i]; m_v[i] = iv[i];
         end
      end
   endtask
   task automatic check_all();
      logic [15:0] s, b;
      for (int i = 0; i < 3; i++) begin
         s = (i == 0) ? sc0 : (i == 1) ? sc1 : {12'h0, sc2};
         b = (i == 0) ? bc0 : (i == 1) ? bc1 : {12'h0, bc2};
         chk($sformatf("u%0d.out_data", i), 32'(dout[i]), 32'(m_out[i]));
         chk($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(m_v[i]));
         chk($sformatf("u%0d.skid_full", i), 32'(sf[i]), (i == 1) ? 32'(m_q.size()) : 32'h0);
         chk($sformatf("u%0d.overflow", i), 32'(of[i]), 32'(m_ovf[i]));
         chk($sformatf("u%0d.stall_cycles", i), 32'(s), 32'(m_sc[i]));
         chk($sformatf("u%0d.bubble_count", i), 32'(b), 32'(m_bc[i]));
      end
   endtask
   task automatic tick();
      @(posedge clock);
      model_update();
      @(negedge clock);
      check_all();
   endtask
   initial begin
      for (int i = 0; i < 3; i++) begin
         din[i] = 8'h00; iv[i] = 1'b0; st[i] = 1'b0; bb[i] = 1'b0; rs[i] = 1'b1;
         m_out[i] = 8'hxx; m_v[i] = 1'bx; m_ovf[i] = 1'bx; m_sc[i] = 0; m_bc[i] = 0;
      end
      tick();
      chk("rst.out_data", 32'(dout[1]), 32'h10);
      chk("rst.out_valid", 32'(ov[1]), 32'h0);
      for (int i = 0; i < 3; i++) rs[i] = 1'b0;
      din[0] = 8'h11; iv[0] = 1'b1;
      din[1] = 8'hA5; iv[1] = 1'b1; st[1] = 1'b1;
      st[2] = 1'b1;
      tick();
      chk("load1", 32'(dout[0]), 32'h11);
      chk("skid_fill", 32'(sf[1]), 32'h1);
      din[0] = 8'h22;
      din[1] = 8'h5A; st[1] = 1'b0;
      tick();
      chk("load2", 32'(dout[0]), 32'h22);
      chk("skid_drain1", 32'(dout[1]), 32'hA5);
      chk("skid_refill", 32'(sf[1]), 32'h1);
      st[0] = 1'b1; bb[0] = 1'b1; iv[0] = 1'b0; din[0] = 8'h77;
      iv[1] = 1'b0;
      tick();
      chk("skid_drain2", 32'(dout[1]), 32'h5A);
      chk("skid_empty", 32'(sf[1]), 32'h0);
      st[1] = 1'b1; iv[1] = 1'b1; din[1] = 8'h33;
      tick();
      din[1] = 8'h44;
      tick();
      chk("stall_hold", 32'(dout[0]), 32'h22);
      chk("stall_cnt3", 32'(sc0), 32'h3);
      chk("stall_nobub", 32'(bc0), 32'h0);
      chk("overflow_set", 32'(of[1]), 32'h1);
      st[0] = 1'b0; bb[0] = 1'b1;
      st[1] = 1'b0; bb[1] = 1'b1; iv[1] = 1'b1; din[1] = 8'h55;
      tick();
      chk("bubble_out", 32'(dout[0]), 32'h10);
      chk("bubble_valid", 32'(ov[0]), 32'h0);
      chk("bubble_cnt", 32'(bc0), 32'h1);
      chk("squash_out", 32'(dout[1]), 32'h10);
      chk("squash_empty", 32'(sf[1]), 32'h0);
      chk("overflow_sticky", 32'(of[1]), 32'h1);
      bb[0] = 1'b0; bb[1] = 1'b0; iv[1] = 1'b0; rs[1] = 1'b1;
      tick();
      chk("rst_overflow", 32'(of[1]), 32'h0);
      chk("rst_counter", 32'(sc1), 32'h0);
      rs[1] = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      chk("sat_stall", 32'(sc2), 32'hF);
      rs[2] = 1'b1;
      tick();
      chk("rst_midstall", 32'(sc2), 32'h0);
      rs[2] = 1'b0;
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 3; i++) begin
            rs[i] = ($urandom_range(0, 31) == 0);
            st[i] = ($urandom_range(0, 2) == 0);
            bb[i] = ($urandom_range(0, 3) == 0);
            iv[i] = 1'($urandom);
            din[i] = 8'($urandom);
         end
         tick();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
